// File: rtl/user_in_conditioner.sv
// Multi-channel input conditioner: synchroniser chain, consecutive-sample debounce and press/release pulses.
// Optional auto-repeat of press while held is enabled with `define AUTOREPEAT_EN. The falling-edge pulse port
// is named release_pulse because "release" is a reserved word.
module user_in_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                any_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("user_in_conditioner: parameter out of range");
  end

  // Counter restarts whenever the sample agrees with the level and after each accepted change.
  function automatic logic [CNT_W-1:0] cnt_next(input logic differ, input logic [CNT_W-1:0] c);
    if (!differ || c == CNT_LAST) return '0;
    return c + 1'b1;
  endfunction

  logic [CHANNELS-1:0] sync_p [SYNC_STAGES];
  logic [CHANNELS-1:0] sync;
  logic [CNT_W-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] accept, rise, fall, press_next;

  // Stage p0..pN: synchroniser chain
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
    end else begin
      sync_p[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  assign sync = sync_p[SYNC_STAGES-1];

  always_comb begin
    accept = '0;
    for (int i = 0; i < CHANNELS; i++)
      accept[i] = (sync[i] != level[i]) && (cnt[i] == CNT_LAST);
  end

  assign rise = accept & sync;
  assign fall = accept & ~sync;

  // Debounce stage: level and per-channel counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      level <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      level <= level ^ accept;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_next(sync[i] != level[i], cnt[i]);
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  logic [RPT_W-1:0]    rpt [CHANNELS];
  logic [CHANNELS-1:0] repeat_fire;

  // rpt counts down to the next repeat; a held level that is not falling this edge may fire.
  always_comb begin
    repeat_fire = '0;
    for (int i = 0; i < CHANNELS; i++)
      repeat_fire[i] = level[i] && !fall[i] && (rpt[i] == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) rpt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (rise[i])                  rpt[i] <= RPT_W'(REPEAT_DELAY - 1);
        else if (!level[i] || fall[i]) rpt[i] <= '0;
        else if (rpt[i] == '0)        rpt[i] <= RPT_W'(REPEAT_PERIOD - 1);
        else                          rpt[i] <= rpt[i] - 1'b1;
      end
    end
  end

  assign press_next = rise | repeat_fire;
`else
  assign press_next = rise;
`endif

  // Output stage: registered pulses aligned with the level update
  always_ff @(posedge clk) begin
    if (!reset) begin
      press         <= '0;
      release_pulse <= '0;
      any_press     <= 1'b0;
    end else begin
      press         <= press_next;
      release_pulse <= fall;
      any_press     <= |press_next;
    end
  end

endmodule

// File: tb/tb_user_in_conditioner.sv
// Testbench for user_in_conditioner: vector table, corner-case sequences and randomized traffic
// compared against a sample-history reference model (auto-repeat modelled when AUTOREPEAT_EN is defined).
module tb_user_in_conditioner;

  localparam int CH   = 2;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] in = '0;
  logic [CH-1:0] level, press, release_pulse;
  logic          any_press;

  int n_tests = 0;
  int n_fail  = 0;

  user_in_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .in(in), .level(level), .press(press),
    .release_pulse(release_pulse), .any_press(any_press)
  );

  always #5 clk = ~clk;

  // Reference model: input delay line, per-channel sample history since the last level change.
  logic [CH-1:0] chain_q[$];
  bit            hist[CH][$];
  int            since[CH];
  logic [CH-1:0] m_lvl, m_press, m_rel;
  logic          m_any;

  function automatic void model_edge(input logic r, input logic [CH-1:0] v);
    logic [CH-1:0] sp, rise, fall;
    bit all_diff;
    rise = '0;
    fall = '0;
    if (!r) begin
      chain_q.delete();
      for (int s = 0; s < SYNC; s++) chain_q.push_back('0);
      for (int c = 0; c < CH; c++) begin hist[c].delete(); since[c] = -1; end
      m_lvl = '0; m_press = '0; m_rel = '0; m_any = 1'b0;
      return;
    end
    sp = chain_q[SYNC-1];
    chain_q.push_front(v);
    void'(chain_q.pop_back());
    for (int c = 0; c < CH; c++) begin
      hist[c].push_back(sp[c]);
      if (hist[c].size() > DEB) void'(hist[c].pop_front());
      if (hist[c].size() == DEB) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) if (hist[c][k] == m_lvl[c]) all_diff = 1'b0;
        if (all_diff) begin
          if (m_lvl[c]) fall[c] = 1'b1; else rise[c] = 1'b1;
          m_lvl[c] = ~m_lvl[c];
          hist[c].delete();
        end
      end
    end
    m_press = rise;
    for (int c = 0; c < CH; c++) begin
      if (rise[c]) since[c] = 0;
      else if (m_lvl[c] && since[c] >= 0) begin
        since[c]++;
        if (AR && since[c] >= RD && (since[c] - RD) % RP == 0) m_press[c] = 1'b1;
      end else since[c] = -1;
    end
    m_rel = fall;
    m_any = |m_press;
  endfunction

  task automatic step(input logic r, input logic [CH-1:0] v);
    @(negedge clk);
    reset = r;
    in    = v;
    @(posedge clk);
    model_edge(r, v);
    #1;
  endtask

  task automatic check(input string name, input logic [CH-1:0] el, input logic [CH-1:0] ep,
                       input logic [CH-1:0] er, input logic ea);
    n_tests++;
    if ({level, press, release_pulse, any_press} !== {el, ep, er, ea}) begin
      n_fail++;
      $display("FAIL %s: got level=%b press=%b release=%b any=%b, expected level=%b press=%b release=%b any=%b",
               name, level, press, release_pulse, any_press, el, ep, er, ea);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_lvl, m_press, m_rel, m_any);
  endtask

  task automatic expect_true(input string name, input bit cond, input int got, input int want);
    n_tests++;
    if (!cond) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  typedef struct {
    logic          rst;
    logic [CH-1:0] vin;
    logic [CH-1:0] lvl;
    logic [CH-1:0] prs;
    logic [CH-1:0] rel;
    logic          any;
  } vec_t;

  vec_t vt[30];

  initial begin
    int rise_at, presses, late_press, bad;
    logic [CH-1:0] rv;
    logic rr;

    // reset, single rise, release, simultaneous rise and fall
    vt[0]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    vt[1]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    for (int k = 2; k <= 6; k++)   vt[k] = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    vt[7]  = '{1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1};
    vt[8]  = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    for (int k = 9; k <= 13; k++)  vt[k] = '{1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
    vt[14] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
    vt[15] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    for (int k = 16; k <= 20; k++) vt[k] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0};
    vt[21] = '{1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1};
    vt[22] = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0};
    for (int k = 23; k <= 27; k++) vt[k] = '{1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0};
    vt[28] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0};
    vt[29] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};

    for (int k = 0; k < 30; k++) begin
      step(vt[k].rst, vt[k].vin);
      check($sformatf("vec%0d", k), vt[k].lvl, vt[k].prs, vt[k].rel, vt[k].any);
    end

    // Glitch: 3 high samples rejected, then 4 high samples accepted
    bad = 0;
    for (int k = 0; k < 3; k++)  begin step(1'b1, 2'b01); check_model("glitch3"); bad += int'(|{level, press, release_pulse}); end
    for (int k = 0; k < 8; k++)  begin step(1'b1, 2'b00); check_model("glitch3_low"); bad += int'(|{level, press, release_pulse}); end
    expect_true("glitch_quiet", bad == 0, bad, 0);
    presses = 0;
    for (int k = 0; k < 4; k++)  begin step(1'b1, 2'b01); check_model("pulse4"); presses += int'(press[0]); end
    for (int k = 0; k < 12; k++) begin step(1'b1, 2'b00); check_model("pulse4_low"); presses += int'(press[0]); end
    expect_true("pulse4_accepted", presses == 1, presses, 1);

    // Reset mid-count discards partial progress; full latency afterwards
    for (int k = 0; k < 3; k++) begin step(1'b1, 2'b01); check_model("midcnt"); end
    step(1'b0, 2'b01);
    check("midcnt_reset", 2'b00, 2'b00, 2'b00, 1'b0);
    rise_at = -1;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 2'b01);
      check_model("post_reset");
      if (rise_at < 0 && level[0]) rise_at = k;
    end
    expect_true("post_reset_latency", rise_at == SYNC + DEB, rise_at, SYNC + DEB);

    // Long hold: auto-repeat pulses (when built in), none after release
    step(1'b0, 2'b00);
    presses = 0;
    for (int k = 0; k < 36; k++) begin
      step(1'b1, 2'b01);
      check_model("hold");
      presses += int'(press[0]);
    end
    // press at edge 6, repeats at 16,19,22,25,28,31,34
    expect_true("hold_presses", presses == (AR ? 8 : 1), presses, AR ? 8 : 1);
    late_press = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 2'b00);
      check_model("after_release");
      if (!level[0]) late_press += int'(press[0]);
    end
    expect_true("no_press_after_release", late_press == 0, late_press, 0);

    // Randomized bursty traffic with occasional resets
    rv = '0;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(4) == 0) rv[c] = ~rv[c];
      rr = ($urandom_range(199) != 0);
      step(rr, rv);
      check_model("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/user_in_conditioner.md
Name: user_in_conditioner

Overview:
Parametrised multi-channel successor to the two-flop user-input synchroniser. Each channel has:
- a configurable-depth synchroniser chain
- a consecutive-sample debounce filter
- edge detection producing a debounced level, a one-cycle press pulse and a one-cycle release pulse

Sits between raw board switches/keys and game-control logic (flap, start, pause), so downstream FSMs see exactly one event per physical press.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, flops in each synchroniser chain (>=2)
DEBOUNCE_CYCLES, 16, consecutive differing synchronised samples required to accept a level change (>=1)
REPEAT_DELAY, 32, cycles from press pulse to first auto-repeat pulse (used only with AUTOREPEAT_EN, >=1)
REPEAT_PERIOD, 8, cycles between subsequent auto-repeat pulses (used only with AUTOREPEAT_EN, >=1)

Ports:
clk  input  1  single system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk edge
in  input  CHANNELS  raw asynchronous inputs, active-high, bit i = channel i
level  output  CHANNELS  debounced level per channel
press  output  CHANNELS  one-cycle pulse on debounced rising edge (plus auto-repeat pulses when enabled)
release  output  CHANNELS  one-cycle pulse on debounced falling edge
any_press  output  1  registered OR of the press vector

Behaviour:
- Reset (reset==0 at a rising edge):
  - all sync flops, counters, level, press, release and any_press go to 0 on that edge
  - a reset asserted mid-count discards any partial count
  - the first post-reset sample is taken on the first edge with reset==1
- Synchroniser: SYNC_STAGES flops per channel; sync_i is the last stage. No other logic reads in[i] directly.
- Debounce, per channel, with counter cnt_i of width $clog2(DEBOUNCE_CYCLES)+1. On each edge:
  - sync_i == level_i: cnt_i <= 0.
  - sync_i != level_i and cnt_i < DEBOUNCE_CYCLES-1: cnt_i <= cnt_i+1.
  - sync_i != level_i and cnt_i == DEBOUNCE_CYCLES-1: level_i <= sync_i, cnt_i <= 0.
- Latency: a clean step on in[i] set up before edge 1 appears on level_i after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Glitches: any pulse or gap shorter than DEBOUNCE_CYCLES synchronised samples leaves level_i unchanged and resets cnt_i.
- Edge outputs:
  - press_i is registered and asserted on the same edge that level_i goes 0->1, for exactly one cycle.
  - release_i behaves likewise on the 1->0 transition.
  - press_i and release_i are never both high.
- any_press: registered alongside press, so it is high in the same cycle as any press bit (one cycle, no extra latency).
- Channel independence: channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses.
- DEBOUNCE_CYCLES=1: level follows sync with one cycle of delay.
- Counter saturation: cnt_i never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

Optional Feature:
Macro AUTOREPEAT_EN.
- Defined: each channel has a repeat counter rpt_i.
  - rpt_i clears on the press pulse and on level_i==0.
  - While level_i stays 1, an extra press_i pulse fires REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles.
  - Each extra pulse also drives any_press.
  - Release clears rpt_i immediately; no repeat pulse is emitted in the release cycle.
  - rpt_i saturates/reloads, never wraps into a spurious pulse.
- Undefined: no repeat logic is synthesised; press fires exactly once per debounced rising edge; REPEAT_* parameters are ignored.

Test Plan:
(CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, reset held 0 for 2 edges, then 1.)
1. Raw rise: in=2'b01 set before edge E and held high -> level[0] goes high after edge E+5; press=2'b01 and any_press=1 for exactly one cycle; level[1]=0 throughout.
2. Glitch rejection: in[0] high for 3 cycles, then low -> level, press and release stay 0. A subsequent 4-cycle high is accepted.
3. Release: from level[0]=1, drop in[0] and hold low -> level[0] falls 6 cycles later; release[0] pulses one cycle; press stays 0.
4. Simultaneous: in 2'b00->2'b11 on one edge -> both level bits rise on the same edge; press=2'b11 for one cycle; any_press is a single one-cycle pulse.
5. Reset mid-count: in[0] high for 2 synchronised samples, then reset=0 for one edge, then reset=1 with in[0] still high -> all outputs 0 after the reset edge; level[0] rises only after the full post-reset latency (SYNC_STAGES+DEBOUNCE_CYCLES=6).
6. With AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=3: hold in[0] high -> press[0] at the first press cycle P, then at P+10, P+13, P+16…; on release, no further pulses. Without the macro: only the pulse at P.
